// File: rtl/data_writeback_cache_controller.sv
// Miss/fill/writeback controller for the 2-way writeback data cache.
// Optional perf counters enabled by defining DCACHE_PERF_CNT_EN.
module data_writeback_cache_controller #(
  parameter int lines = 1024,
  parameter int tbits = 18,
  parameter int bsize = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemRE,
  input  logic             MemWE,
  input  logic [31:0]      A,
  input  logic [tbits-1:0] PhysTag,
  input  logic [3:0]       ByteMask,
  input  logic             W1V,
  input  logic             W2V,
  input  logic             W1D,
  input  logic             W2D,
  input  logic [tbits-1:0] W1Tag,
  input  logic [tbits-1:0] W2Tag,
  input  logic             CurrLRU,
  input  logic             BusReady,
  output logic             W1WE,
  output logic             W2WE,
  output logic             DirtyIn,
  output logic             vin,
  output logic [3:0]       ActiveByteMask,
  output logic [1:0]       CacheRDSel,
  output logic [31:0]      ANew,
  output logic             CacheWDSel,
  output logic             WBWaySel,
  output logic             BusRE,
  output logic             BusWE,
  output logic [31:0]      BusAddr,
  output logic             Stall,
  output logic [31:0]      HitCount,
  output logic [31:0]      MissCount,
  output logic [31:0]      WBCount
);

  localparam int setbits = $clog2(lines);
  localparam int wbits   = $clog2(bsize);
  localparam logic [wbits-1:0] LAST = wbits'(bsize - 1);

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH} state_t;

  state_t             state;
  logic [wbits-1:0]   cnt;
  logic               victim;      // 0 = way1, 1 = way2

  logic               h1, h2, hit, req;
  logic               nvictim, nvictim_dirty;
  logic [setbits-1:0] set;
  logic [tbits-1:0]   vtag;
  logic               unused_bits;

  assign unused_bits = ^A[1:0];
  assign set = A[setbits+3:4];
  assign h1  = W1V & (W1Tag == PhysTag);
  assign h2  = W2V & (W2Tag == PhysTag);
  assign hit = h1 | h2;
  assign req = MemRE | MemWE;

  // Invalid ways are filled first; otherwise evict the least recently written way.
  always_comb begin
    nvictim = 1'b0;
    if (!W1V)      nvictim = 1'b0;
    else if (!W2V) nvictim = 1'b1;
    else           nvictim = ~CurrLRU;
    nvictim_dirty = nvictim ? (W2V & W2D) : (W1V & W1D);
  end

  assign vtag = victim ? W2Tag : W1Tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      victim <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            victim <= nvictim;
            state  <= nvictim_dirty ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: begin
          if (BusReady) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= FETCH;
          end
        end
        FETCH: begin
          if (BusReady) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Reset gates every strobe so an in-flight transaction is aborted that cycle.
  always_comb begin
    W1WE           = 1'b0;
    W2WE           = 1'b0;
    DirtyIn        = 1'b0;
    vin            = 1'b0;
    ActiveByteMask = '0;
    CacheRDSel     = A[3:2];
    ANew           = A;
    CacheWDSel     = 1'b0;
    WBWaySel       = 1'b0;
    BusRE          = 1'b0;
    BusWE          = 1'b0;
    BusAddr        = '0;
    Stall          = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (MemWE) begin
                W1WE           = h1;
                W2WE           = h2;
                DirtyIn        = 1'b1;
                vin            = 1'b1;
                ActiveByteMask = ByteMask;
              end
            end else begin
              Stall = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          Stall      = 1'b1;
          BusWE      = 1'b1;
          BusAddr    = {vtag, set, cnt, 2'b00};
          CacheRDSel = cnt;
          WBWaySel   = victim;
        end
        FETCH: begin
          Stall   = 1'b1;
          BusRE   = 1'b1;
          BusAddr = {PhysTag, set, cnt, 2'b00};
          ANew    = {A[31:4], cnt, 2'b00};
          if (BusReady) begin
            W1WE           = ~victim;
            W2WE           = victim;
            CacheWDSel     = 1'b1;
            vin            = 1'b1;
            ActiveByteMask = 4'hF;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic replay;

  always_ff @(posedge clk) begin
    if (reset) begin
      replay    <= 1'b0;
      HitCount  <= '0;
      MissCount <= '0;
      WBCount   <= '0;
    end else begin
      replay <= (state == FETCH) && BusReady && (cnt == LAST);
      if (state == IDLE && req) begin
        if (hit && !replay) HitCount <= HitCount + 32'd1;
        if (!hit) begin
          MissCount <= MissCount + 32'd1;
          if (nvictim_dirty) WBCount <= WBCount + 32'd1;
        end
      end
    end
  end
`else
  assign HitCount  = 32'h0;
  assign MissCount = 32'h0;
  assign WBCount   = 32'h0;
`endif

endmodule

// File: tb/tb_data_writeback_cache_controller.sv
// Directed bench for data_writeback_cache_controller: hits, clean/dirty misses,
// bus stalls mid-fill and reset during a fill.
module tb_data_writeback_cache_controller;

  logic        clk = 1'b0;
  logic        reset, MemRE, MemWE;
  logic [31:0] A;
  logic [17:0] PhysTag, W1Tag, W2Tag;
  logic [3:0]  ByteMask;
  logic        W1V, W2V, W1D, W2D, CurrLRU, BusReady;
  logic        W1WE, W2WE, DirtyIn, vin, CacheWDSel, WBWaySel, BusRE, BusWE, Stall;
  logic [3:0]  ActiveByteMask;
  logic [1:0]  CacheRDSel;
  logic [31:0] ANew, BusAddr, HitCount, MissCount, WBCount;

  int vectors = 0;
  int fails   = 0;

  always #5 clk = ~clk;

  data_writeback_cache_controller #(.lines(1024), .tbits(18), .bsize(4)) dut (
    .clk(clk), .reset(reset), .MemRE(MemRE), .MemWE(MemWE), .A(A), .PhysTag(PhysTag),
    .ByteMask(ByteMask), .W1V(W1V), .W2V(W2V), .W1D(W1D), .W2D(W2D),
    .W1Tag(W1Tag), .W2Tag(W2Tag), .CurrLRU(CurrLRU), .BusReady(BusReady),
    .W1WE(W1WE), .W2WE(W2WE), .DirtyIn(DirtyIn), .vin(vin),
    .ActiveByteMask(ActiveByteMask), .CacheRDSel(CacheRDSel), .ANew(ANew),
    .CacheWDSel(CacheWDSel), .WBWaySel(WBWaySel), .BusRE(BusRE), .BusWE(BusWE),
    .BusAddr(BusAddr), .Stall(Stall),
    .HitCount(HitCount), .MissCount(MissCount), .WBCount(WBCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_perf(input logic [31:0] h, input logic [31:0] m, input logic [31:0] w);
`ifdef DCACHE_PERF_CNT_EN
    chk("hitcount", HitCount, h);
    chk("misscount", MissCount, m);
    chk("wbcount", WBCount, w);
`else
    chk("hitcount_tied", HitCount, 32'h0);
    chk("misscount_tied", MissCount, 32'h0);
    chk("wbcount_tied", WBCount, 32'h0);
    if (h == m && m == w) ; // counts only meaningful when counters are built
`endif
  endtask

  initial begin
    reset = 1'b1; MemRE = 1'b0; MemWE = 1'b0; A = 32'h0000_1234;
    PhysTag = '0; W1Tag = '0; W2Tag = '0; ByteMask = '0;
    W1V = 1'b0; W2V = 1'b0; W1D = 1'b0; W2D = 1'b0; CurrLRU = 1'b0; BusReady = 1'b0;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    chk("rst_stall", Stall, 0);
    chk("rst_anew", ANew, 32'h0000_1234);
    chk("rst_rdsel", CacheRDSel, 2'b01);
    chk("rst_bus", {BusRE, BusWE}, 0);
    chk("rst_we", {W1WE, W2WE}, 0);
    chk_perf(0, 0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Read hit in way1
    MemRE = 1'b1; PhysTag = 18'h2A5A5; W1V = 1'b1; W1Tag = 18'h2A5A5; #1;
    chk("rdhit_stall", Stall, 0);
    chk("rdhit_rdsel", CacheRDSel, 2'b01);
    chk("rdhit_bus", {BusRE, BusWE}, 0);
    chk("rdhit_we", {W1WE, W2WE}, 0);
    @(negedge clk);

    // Store hit in way2
    MemRE = 1'b0; MemWE = 1'b1; W1Tag = 18'h00111; W2V = 1'b1; W2Tag = 18'h2A5A5;
    ByteMask = 4'b0011; #1;
    chk("sthit_we", {W1WE, W2WE}, 2'b01);
    chk("sthit_dirty", {DirtyIn, vin}, 2'b11);
    chk("sthit_mask", ActiveByteMask, 4'b0011);
    chk("sthit_stall", Stall, 0);
    @(negedge clk);
    MemWE = 1'b0; #1;
    chk("sthit_pulse", {W1WE, W2WE}, 0);
    @(negedge clk);

    // Clean miss, both valid, CurrLRU=0 -> victim way2, straight to fill
    A = 32'hABCD_5678; PhysTag = 18'h12345; W1Tag = 18'h00111; W2Tag = 18'h00222;
    W1D = 1'b1; W2D = 1'b0; CurrLRU = 1'b0; MemRE = 1'b1; #1;
    chk("miss_stall", Stall, 1);
    chk("miss_bus", {BusRE, BusWE}, 0);
    chk("miss_we", {W1WE, W2WE}, 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        BusReady = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("hold_addr", BusAddr, 32'h48D1_5678);
          chk("hold_we", {W1WE, W2WE}, 0);
          chk("hold_stall_re", {Stall, BusRE}, 2'b11);
          @(negedge clk);
        end
      end
      BusReady = 1'b1; #1;
      chk("fill_addr", BusAddr, 32'h48D1_5670 + 32'(4 * i));
      chk("fill_anew", ANew, 32'hABCD_5670 + 32'(4 * i));
      chk("fill_bus", {BusRE, BusWE}, 2'b10);
      chk("fill_we", {W1WE, W2WE}, 2'b01);
      chk("fill_ctl", {CacheWDSel, vin, DirtyIn}, 3'b110);
      chk("fill_mask", ActiveByteMask, 4'hF);
      chk("fill_stall", Stall, 1);
      @(negedge clk);
    end
    BusReady = 1'b0; W2Tag = 18'h12345; #1;
    chk("replay_stall", Stall, 0);
    chk("replay_bus", {BusRE, BusWE}, 0);
    @(negedge clk);
    MemRE = 1'b0;

    // Dirty victim way1 (CurrLRU=1), store miss: 4 writeback beats then 4 fill beats
    PhysTag = 18'h3C0F0; CurrLRU = 1'b1; W1D = 1'b1; W2D = 1'b0; MemWE = 1'b1;
    ByteMask = 4'b1100; #1;
    chk("dmiss_stall", Stall, 1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      BusReady = 1'b1; #1;
      chk("wb_bus", {BusRE, BusWE}, 2'b01);
      chk("wb_addr", BusAddr, 32'h0044_5670 + 32'(4 * i));
      chk("wb_rdsel", CacheRDSel, 32'(i));
      chk("wb_way", WBWaySel, 0);
      chk("wb_we", {W1WE, W2WE}, 0);
      chk("wb_stall", Stall, 1);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("dfill_bus", {BusRE, BusWE}, 2'b10);
      chk("dfill_addr", BusAddr, 32'hF03C_1670 + 32'(4 * i));
      chk("dfill_we", {W1WE, W2WE}, 2'b10);
      @(negedge clk);
    end
    BusReady = 1'b0; W1Tag = 18'h3C0F0; W1D = 1'b0; #1;
    chk("dreplay_stall", Stall, 0);
    chk("dreplay_we", {W1WE, W2WE}, 2'b10);
    chk("dreplay_dirty", DirtyIn, 1);
    chk("dreplay_mask", ActiveByteMask, 4'b1100);
    @(negedge clk);
    MemWE = 1'b0; #1;
    chk_perf(2, 2, 1);
    @(negedge clk);

    // Reset during FETCH with Cnt=2
    PhysTag = 18'h00333; CurrLRU = 1'b0; MemRE = 1'b1;
    @(negedge clk);
    BusReady = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b1; #1;
    chk("rstf_bus", {BusRE, BusWE}, 0);
    chk("rstf_we", {W1WE, W2WE}, 0);
    chk("rstf_stall", Stall, 0);
    @(negedge clk);
    reset = 1'b0; MemRE = 1'b0; BusReady = 1'b0; #1;
    chk("post_rst_bus", {BusRE, BusWE}, 0);
    chk("post_rst_stall", Stall, 0);
    chk_perf(0, 0, 0);
    @(negedge clk);
    MemRE = 1'b1; #1;
    chk("post_rst_miss", Stall, 1);
    @(negedge clk); #1;
    chk("post_rst_cnt0", BusAddr, 32'h00CC_D670);
    chk("post_rst_re", BusRE, 1);
    MemRE = 1'b0; reset = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
